// File: rtl/uart_mem_bridge_if.sv
// Byte-stream, transmitter and memory-bus signals of the UART memory bridge.
// The bridge connects through the master modport and its surroundings through the slave modport.
interface uart_mem_bridge_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        overrun;

  modport master (
    input  rx_valid, rx_data, tx_busy, mem_gnt, mem_rvalid, mem_rdata,
    output tx_start, tx_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata, overrun
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, mem_gnt, mem_rvalid, mem_rdata,
    input  tx_start, tx_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata, overrun
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// Decodes host command frames from the UART byte stream, performs 32-bit memory
// reads/writes on the core bus and returns the reply bytes through the transmitter.
module uart_mem_bridge #(
  parameter int          TIMEOUT_CYCLES = 400000,
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  CMD_READ       = 8'h52,
  parameter logic [7:0]  RSP_ACK        = 8'h4B,
  parameter logic [7:0]  RSP_NAK        = 8'h3F
) (
  input  logic clk,
  input  logic rst,
  uart_mem_bridge_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, MEM_REQ, MEM_WAIT, RESP
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t        state, nextState;
  logic [1:0]    byteCnt;
  logic          isWrite;
  logic [31:0]   addrReg;
  logic [31:0]   wdataReg;
  logic [31:0]   replyReg;
  logic [1:0]    txIdx;
  logic [1:0]    txLast;
  logic          awaitBusy;
  logic          awaitIdle;
  logic          txStartQ;
  logic          txStart;
  logic          timedOut;
  logic          overrunReg;
  logic [TW-1:0] timer;

  // Next-state decode; a tx byte may only be launched once the previous one was seen busy and then idle
  always_comb begin
    nextState = state;
    txStart   = 1'b0;
    timedOut  = (timer == TW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) nextState = ADDR;
          else nextState = RESP;
        end
      end
      ADDR: begin
        if (bus.rx_valid) begin
          if (byteCnt == 2'd3) nextState = isWrite ? WDATA : MEM_REQ;
        end else if (timedOut) begin
          nextState = IDLE;
        end
      end
      WDATA: begin
        if (bus.rx_valid) begin
          if (byteCnt == 2'd3) nextState = MEM_REQ;
        end else if (timedOut) begin
          nextState = IDLE;
        end
      end
      MEM_REQ: begin
        if (bus.mem_gnt) nextState = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_rvalid) nextState = RESP;
      end
      RESP: begin
        txStart = !awaitBusy && !awaitIdle && !bus.tx_busy && !txStartQ;
        if (txStart && txIdx == txLast) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Frame assembly, reply capture, tx pacing and the inter-byte watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      byteCnt    <= '0;
      isWrite    <= 1'b0;
      addrReg    <= '0;
      wdataReg   <= '0;
      replyReg   <= '0;
      txIdx      <= '0;
      txLast     <= '0;
      awaitBusy  <= 1'b0;
      awaitIdle  <= 1'b0;
      txStartQ   <= 1'b0;
      overrunReg <= 1'b0;
      timer      <= '0;
    end else begin
      txStartQ <= txStart;
      if ((state == ADDR || state == WDATA) && !bus.rx_valid) timer <= timer + TW'(1);
      else timer <= '0;
      if (bus.rx_valid && (state == MEM_REQ || state == MEM_WAIT || state == RESP))
        overrunReg <= 1'b1;
      case (state)
        IDLE: begin
          byteCnt   <= '0;
          awaitBusy <= 1'b0;
          awaitIdle <= 1'b0;
          if (bus.rx_valid) begin
            isWrite  <= (bus.rx_data == CMD_WRITE);
            replyReg <= {24'h0, RSP_NAK};
            txIdx    <= '0;
            txLast   <= '0;
          end
        end
        ADDR: begin
          if (bus.rx_valid) begin
            addrReg[{byteCnt, 3'b000} +: 8] <= bus.rx_data;
            byteCnt <= byteCnt + 2'd1;
          end
        end
        WDATA: begin
          if (bus.rx_valid) begin
            wdataReg[{byteCnt, 3'b000} +: 8] <= bus.rx_data;
            byteCnt <= byteCnt + 2'd1;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_rvalid) begin
            txIdx <= '0;
            if (isWrite) begin
              replyReg <= {24'h0, RSP_ACK};
              txLast   <= 2'd0;
            end else begin
              replyReg <= bus.mem_rdata;
              txLast   <= 2'd3;
            end
          end
        end
        RESP: begin
          if (txStart) begin
            txIdx     <= txIdx + 2'd1;
            awaitBusy <= 1'b1;
          end else if (awaitBusy && bus.tx_busy) begin
            awaitBusy <= 1'b0;
            awaitIdle <= 1'b1;
          end else if (awaitIdle && !bus.tx_busy) begin
            awaitIdle <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_start  = txStart;
  assign bus.tx_data   = replyReg[{txIdx, 3'b000} +: 8];
  assign bus.mem_req   = (state == MEM_REQ);
  assign bus.mem_we    = isWrite;
  assign bus.mem_addr  = addrReg & 32'hFFFF_FFFC;
  assign bus.mem_be    = 4'hF;
  assign bus.mem_wdata = wdataReg;
  assign bus.overrun   = overrunReg;

endmodule
